// File: rtl/ctrl_pipe_pkg.sv
// Shared definitions for the control-bundle pipeline: bundle field offsets,
// the codebase kill mask (drop REGWRITE) and the default bundle width.
package ctrl_pipe_pkg;

  localparam int CP_WIDTH = 12;

  // Bundle field offsets (ALUCTRL occupies the top six bits)
  localparam int MEMTOREG   = 0;
  localparam int MEMWRITE   = 1;
  localparam int REGWRITE   = 2;
  localparam int ALUSRC     = 3;
  localparam int REGDST     = 4;
  localparam int CP0WRITE   = 5;
  localparam int ALUCTRL    = 6;
  localparam int ALUCTRL_W  = 6;

  localparam logic [CP_WIDTH-1:0] CP_KILL_MASK = CP_WIDTH'(1) << REGWRITE;

endpackage

// File: rtl/ctrl_pipe_stage.sv
// One pipeline register (bundle + valid) with reset > flush > hold > bubble > load
// priority; an invalid stage always carries a zero bundle.
module ctrl_pipe_stage #(
  parameter int WIDTH = 12
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] i_src_bus,
  input  logic             i_src_valid,
  input  logic             i_flush,
  input  logic             i_hold,
  input  logic             i_bubble,
  input  logic [WIDTH-1:0] i_kill_mask_eff,
  output logic [WIDTH-1:0] o_bus,
  output logic             o_valid,
  output logic             o_valid_nxt
);

  logic [WIDTH-1:0] r_bus;
  logic             r_valid;
  logic [WIDTH-1:0] w_bus_nxt;
  logic             w_valid_nxt;

  always_comb begin
    w_bus_nxt   = r_bus;
    w_valid_nxt = r_valid;
    if (rst || i_flush) begin
      w_bus_nxt   = '0;
      w_valid_nxt = 1'b0;
    end else if (i_hold) begin
      w_bus_nxt   = r_bus;
      w_valid_nxt = r_valid;
    end else if (i_bubble) begin
      w_bus_nxt   = '0;
      w_valid_nxt = 1'b0;
    end else begin
      w_valid_nxt = i_src_valid;
      w_bus_nxt   = i_src_valid ? (i_src_bus & ~i_kill_mask_eff) : '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_bus   <= '0;
      r_valid <= 1'b0;
    end else begin
      r_bus   <= w_bus_nxt;
      r_valid <= w_valid_nxt;
    end
  end

  assign o_bus       = r_bus;
  assign o_valid     = r_valid;
  assign o_valid_nxt = w_valid_nxt;

endmodule

// File: rtl/ctrl_pipe.sv
// Carries decoded control bundles through STAGES registers with per-stage stall,
// flush, downstream stall propagation, bubble insertion, a kill mask and occupancy.
module ctrl_pipe
  import ctrl_pipe_pkg::*;
#(
  parameter int              WIDTH      = CP_WIDTH,
  parameter int              STAGES     = 3,
  parameter int              KILL_STAGE = 1,
  parameter logic [WIDTH-1:0] KILL_MASK = '0
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  input  logic [WIDTH-1:0]            in_bus,
  input  logic [STAGES-1:0]           stall,
  input  logic [STAGES-1:0]           flush,
  input  logic                        kill,
  output logic [STAGES*WIDTH-1:0]     stage_bus,
  output logic [STAGES-1:0]           stage_valid,
  output logic [STAGES-1:0]           stall_eff,
  output logic [$clog2(STAGES+1)-1:0] occupancy
);

  localparam int OCC_W = $clog2(STAGES+1);

  logic [STAGES-1:0] w_stall_eff;
  logic [STAGES-1:0] w_valid_nxt;
  logic [OCC_W-1:0]  w_occ_nxt;
  logic [OCC_W-1:0]  r_occ;

  // A stall anywhere downstream freezes this stage and everything above it
  assign w_stall_eff[STAGES-1] = stall[STAGES-1];
  for (genvar g = 0; g < STAGES-1; g++) begin : g_chain
    assign w_stall_eff[g] = stall[g] | w_stall_eff[g+1];
  end

  for (genvar g = 0; g < STAGES; g++) begin : g_stage
    logic [WIDTH-1:0] w_src_bus;
    logic             w_src_valid;
    logic             w_bubble;
    logic [WIDTH-1:0] w_kill_mask_eff;

    if (g == 0) begin : g_src_dec
      assign w_src_bus   = in_bus;
      assign w_src_valid = in_valid;
      assign w_bubble    = 1'b0;
    end else begin : g_src_prev
      assign w_src_bus   = stage_bus[(g-1)*WIDTH +: WIDTH];
      assign w_src_valid = stage_valid[g-1];
      assign w_bubble    = w_stall_eff[g-1];
    end

    if (g == KILL_STAGE) begin : g_kill
      assign w_kill_mask_eff = KILL_MASK & {WIDTH{kill}};
    end else begin : g_nokill
      assign w_kill_mask_eff = '0;
    end

    ctrl_pipe_stage #(.WIDTH(WIDTH)) u_stage (
      .clk             (clk),
      .rst             (rst),
      .i_src_bus       (w_src_bus),
      .i_src_valid     (w_src_valid),
      .i_flush         (flush[g]),
      .i_hold          (w_stall_eff[g]),
      .i_bubble        (w_bubble),
      .i_kill_mask_eff (w_kill_mask_eff),
      .o_bus           (stage_bus[g*WIDTH +: WIDTH]),
      .o_valid         (stage_valid[g]),
      .o_valid_nxt     (w_valid_nxt[g])
    );
  end

  always_comb begin
    w_occ_nxt = '0;
    for (int i = 0; i < STAGES; i++) begin
      w_occ_nxt = w_occ_nxt + OCC_W'(w_valid_nxt[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) r_occ <= '0;
    else     r_occ <= w_occ_nxt;
  end

  assign stall_eff = w_stall_eff;
  assign occupancy = r_occ;

endmodule
